// File: rtl/uart_pkg.sv
// uart_pkg: shared parity/FSM types and counter-width helpers for uart_core_cfg.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  function automatic int bit_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction
  function automatic int smp_cnt_w(input int os);
    return $clog2(os);
  endfunction
  function automatic parity_e to_parity(input logic [1:0] p);
    return p == 2'd1 ? PAR_EVEN : p == 2'd2 ? PAR_ODD : PAR_NONE;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, one-cycle tick every cfg_div+1 cycles.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 UCLK,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  // >= keeps the counter bounded if cfg_div shrinks below the current count
  always_comb begin
    tick  = cnt_q >= cfg_div;
    cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
  end
  always_ff @(posedge UCLK or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_core_cfg.sv
// uart_core_cfg: runtime-configurable UART (tick, TX serialiser, RX oversampler).
// UART_LOOPBACK_EN adds a loopback input that routes internal tx into the RX path.
module uart_core_cfg import uart_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  UCLK,
  input  logic                  reset,
`ifdef UART_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_frame_err,
  output logic                  rx_parity_err,
  output logic                  rx_overrun
);
  localparam int BIT_CNT_W = bit_cnt_w(DATA_WIDTH);
  localparam int SMP_CNT_W = smp_cnt_w(OVERSAMPLE);
  localparam logic [SMP_CNT_W-1:0] SMP_LAST = SMP_CNT_W'(OVERSAMPLE - 1);
  localparam logic [SMP_CNT_W-1:0] SMP_MID  = SMP_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
  logic tick, tx_int, rx_src, tx_end, rx_mid, stop_smp, consume, load;
  tx_state_e tx_st_q, tx_st_d;
  rx_state_e rx_st_q, rx_st_d;
  logic [SMP_CNT_W-1:0] tx_smp_q, tx_smp_d, rx_smp_q, rx_smp_d;
  logic [BIT_CNT_W-1:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q;
  logic tx_pbit_q, tx_pbit_d, tx_pen_q, tx_pen_d, tx_stop2_q, tx_stop2_d;
  parity_e rx_pm_q, rx_pm_d;
  logic rx_perr_q, rx_perr_d, rx_s1_q, rx_s2_q, rx_s3_q;
  logic rx_valid_q, rx_fe_q, rx_pe_q, rx_ovr_q;
  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (.UCLK(UCLK), .reset(reset), .cfg_div(cfg_div), .tick(tick));
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_int : rx;
  assign tx     = loopback ? 1'b1 : tx_int;
`else
  assign rx_src = rx;
  assign tx     = tx_int;
`endif
  assign tx_ready = tx_st_q == TX_IDLE;
  assign tx_int   = tx_st_q == TX_START ? 1'b0 : tx_st_q == TX_DATA ? tx_sh_q[0] :
                    tx_st_q == TX_PARITY ? tx_pbit_q : 1'b1;
  always_comb begin
    tx_st_d = tx_st_q; tx_smp_d = tx_smp_q; tx_bit_d = tx_bit_q; tx_sh_d = tx_sh_q;
    tx_pbit_d = tx_pbit_q; tx_pen_d = tx_pen_q; tx_stop2_d = tx_stop2_q;
    tx_end = tick && tx_smp_q == SMP_LAST;
    if (tx_st_q == TX_IDLE) begin
      tx_smp_d = '0;
      tx_bit_d = '0;
      if (tx_valid) begin
        tx_st_d    = TX_START;
        tx_sh_d    = tx_data;
        tx_pen_d   = to_parity(cfg_parity) != PAR_NONE;
        tx_pbit_d  = ^tx_data ^ (to_parity(cfg_parity) == PAR_ODD);
        tx_stop2_d = cfg_stop2;
      end
    end else if (tick) begin
      tx_smp_d = tx_end ? '0 : tx_smp_q + 1'b1;
      if (tx_end)
        case (tx_st_q)
          TX_START: tx_st_d = TX_DATA;
          TX_DATA: begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q == BIT_LAST ? '0 : tx_bit_q + 1'b1;
            if (tx_bit_q == BIT_LAST) tx_st_d = tx_pen_q ? TX_PARITY : TX_STOP;
          end
          TX_PARITY: tx_st_d = TX_STOP;
          // tx_bit_q marks the first of two stop periods already sent
          default: begin
            tx_bit_d = 1'b1;
            if (!(tx_stop2_q && tx_bit_q == '0)) tx_st_d = TX_IDLE;
          end
        endcase
    end
  end
  always_comb begin
    rx_st_d = rx_st_q; rx_smp_d = rx_smp_q; rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q;
    rx_pm_d = rx_pm_q; rx_perr_d = rx_perr_q; stop_smp = 1'b0;
    rx_mid = tick && rx_smp_q == (rx_st_q == RX_START ? SMP_MID : SMP_LAST);
    if (rx_st_q == RX_IDLE) begin
      rx_smp_d = '0;
      rx_bit_d = '0;
      if (rx_s3_q && !rx_s2_q) begin
        rx_st_d   = RX_START;
        rx_pm_d   = to_parity(cfg_parity);
        rx_perr_d = 1'b0;
      end
    end else if (tick) begin
      rx_smp_d = rx_mid ? '0 : rx_smp_q + 1'b1;
      if (rx_mid)
        case (rx_st_q)
          RX_START: rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
          RX_DATA: begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_WIDTH-1:1]};
            rx_bit_d = rx_bit_q + 1'b1;
            if (rx_bit_q == BIT_LAST) rx_st_d = rx_pm_q == PAR_NONE ? RX_STOP : RX_PARITY;
          end
          RX_PARITY: begin
            rx_perr_d = rx_s2_q != (^rx_sh_q ^ (rx_pm_q == PAR_ODD));
            rx_st_d   = RX_STOP;
          end
          default: begin
            stop_smp = 1'b1;
            rx_st_d  = RX_IDLE;
          end
        endcase
    end
  end
  // a consume in the same cycle as a stop sample frees the slot for the new frame
  assign consume = rx_valid_q && rx_ready;
  assign load    = stop_smp && (!rx_valid_q || consume);
  always_ff @(posedge UCLK or posedge reset)
    if (reset) begin
      tx_st_q <= TX_IDLE; tx_smp_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0;
      tx_pbit_q <= 1'b0; tx_pen_q <= 1'b0; tx_stop2_q <= 1'b0;
      rx_st_q <= RX_IDLE; rx_smp_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
      rx_pm_q <= PAR_NONE; rx_perr_q <= 1'b0;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
      rx_data_q <= '0; rx_valid_q <= 1'b0; rx_fe_q <= 1'b0; rx_pe_q <= 1'b0; rx_ovr_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d; tx_smp_q <= tx_smp_d; tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
      tx_pbit_q <= tx_pbit_d; tx_pen_q <= tx_pen_d; tx_stop2_q <= tx_stop2_d;
      rx_st_q <= rx_st_d; rx_smp_q <= rx_smp_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      rx_pm_q <= rx_pm_d; rx_perr_q <= rx_perr_d;
      rx_s1_q <= rx_src; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
      rx_valid_q <= load || (rx_valid_q && !consume);
      rx_ovr_q   <= (stop_smp && !load) || (rx_ovr_q && !consume);
      if (load) begin
        rx_data_q <= rx_sh_q;
        rx_fe_q   <= !rx_s2_q;
        rx_pe_q   <= rx_perr_q;
      end
    end
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_fe_q;
  assign rx_parity_err = rx_pe_q;
  assign rx_overrun    = rx_ovr_q;
endmodule
